// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between a core-side initiator and dmem_responder.
// The initiator takes the master modport; the responder takes the slave modport.
interface dmem_responder_if;
  logic [31:0] mem_d_addr_i;
  logic [31:0] mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic        mem_d_cacheable_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_invalidate_i;
  logic        mem_d_writeback_i;
  logic        mem_d_flush_i;
  logic [31:0] mem_d_data_rd_o;
  logic        mem_d_accept_o;
  logic        mem_d_ack_o;
  logic        mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;

  modport slave (
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
           mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
  );

  modport master (
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
           mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory with tagged in-order responses.
// Define DMEM_RESP_STALL_EN to throttle request acceptance with a 16-bit LFSR.
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE_EXT  = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(DEPTH_WORDS) * 33'd4;

  typedef struct packed {
    logic        valid;
    logic [10:0] tag;
    logic        err;
    logic        data_ok;
  } ctl_t;

  logic             accept;
  logic             is_wr;
  logic             is_access;
  logic             is_req;
  logic             taken;
  logic             in_window;
  logic             wr_en;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [32:0]      addr_ext;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      mem_rd_reg;
  ctl_t             ctl_in;
  ctl_t             ctl_out;
  logic [31:0]      data_out;
  logic             unused_bits;

  assign is_wr     = |bus.mem_d_wr_i;
  assign is_access = bus.mem_d_rd_i | is_wr;
  assign is_req    = is_access | bus.mem_d_flush_i | bus.mem_d_invalidate_i | bus.mem_d_writeback_i;
  assign taken     = is_req & accept;

  // Window test is done one bit wider so a window ending at 2^32 cannot wrap.
  assign addr_ext  = {1'b0, bus.mem_d_addr_i};
  assign in_window = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
  assign offset    = bus.mem_d_addr_i - ADDR_BASE;
  assign idx       = offset[IDX_W+1:2];
  assign wr_en     = taken & in_window & is_wr;

`ifdef DMEM_RESP_STALL_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end

  assign accept = rst_i & (lfsr_reg[1:0] != 2'b11);
`else
  assign accept = rst_i;
`endif

  // Registered read sees the pre-write word when a read and write share an edge.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en && bus.mem_d_wr_i[k]) begin
        mem[idx][8*k +: 8] <= bus.mem_d_data_wr_i[8*k +: 8];
      end
    end
    mem_rd_reg <= mem[idx];
  end

  always_comb begin
    ctl_in         = '0;
    ctl_in.valid   = taken;
    ctl_in.tag     = bus.mem_d_req_tag_i;
    ctl_in.err     = is_access & ~in_window;
    ctl_in.data_ok = bus.mem_d_rd_i & in_window;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      ctl_t        ctl_reg;
      logic [31:0] data_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            ctl_reg <= '0;
          end else begin
            ctl_reg <= ctl_in;
          end
        end
        assign data_reg = mem_rd_reg;
      end else begin : g_tail
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            ctl_reg <= '0;
          end else begin
            ctl_reg <= g_stage[gi-1].ctl_reg;
          end
        end
        // Data travels unreset; valid/data_ok gate it at the output.
        always_ff @(posedge clk_i) begin
          data_reg <= g_stage[gi-1].data_reg;
        end
      end
    end
  endgenerate

  assign ctl_out  = g_stage[LATENCY-1].ctl_reg;
  assign data_out = g_stage[LATENCY-1].data_reg;

  assign bus.mem_d_accept_o   = accept;
  assign bus.mem_d_ack_o      = ctl_out.valid;
  assign bus.mem_d_error_o    = ctl_out.valid & ctl_out.err;
  assign bus.mem_d_resp_tag_o = ctl_out.valid ? ctl_out.tag : 11'd0;
  assign bus.mem_d_data_rd_o  = (ctl_out.valid && ctl_out.data_ok) ? data_out : 32'd0;

  assign unused_bits = ^{bus.mem_d_cacheable_i, offset[31:IDX_W+2], offset[1:0]};
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters (LATENCY=2, 1024 words at 0x80000000).
// Every cycle is checked: a due response must match, otherwise all response outputs must be zero.
module tb_dmem_responder;
  localparam int LAT = 2;

  typedef struct {
    int          due;
    logic [10:0] tag;
    logic        err;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  logic  clk_i = 1'b0;
  logic  rst_i = 1'b0;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string step_name = "reset";
  exp_t  exp_q[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_BASE  (32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", step_name, name, obs, expv);
    end
  endtask

  task automatic clear_in();
    bus.mem_d_addr_i       = 32'd0;
    bus.mem_d_data_wr_i    = 32'd0;
    bus.mem_d_rd_i         = 1'b0;
    bus.mem_d_wr_i         = 4'd0;
    bus.mem_d_cacheable_i  = 1'b0;
    bus.mem_d_req_tag_i    = 11'd0;
    bus.mem_d_invalidate_i = 1'b0;
    bus.mem_d_writeback_i  = 1'b0;
    bus.mem_d_flush_i      = 1'b0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    cyc++;
    cmp("accept", 32'(bus.mem_d_accept_o), 32'd1);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      cmp("ack", 32'(bus.mem_d_ack_o), 32'd1);
      cmp("tag", 32'(bus.mem_d_resp_tag_o), 32'(e.tag));
      cmp("err", 32'(bus.mem_d_error_o), 32'(e.err));
      if (e.chk_data) cmp("data", bus.mem_d_data_rd_o, e.data);
    end else begin
      cmp("idle_ack", 32'(bus.mem_d_ack_o), 32'd0);
      cmp("idle_tag", 32'(bus.mem_d_resp_tag_o), 32'd0);
      cmp("idle_err", 32'(bus.mem_d_error_o), 32'd0);
      cmp("idle_data", bus.mem_d_data_rd_o, 32'd0);
    end
  endtask

  // maint = {flush, invalidate, writeback}
  task automatic issue(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [10:0] tag, input logic [2:0] maint,
                       input logic eerr, input logic [31:0] edata, input bit chk);
    exp_t e;
    bus.mem_d_rd_i         = rd;
    bus.mem_d_wr_i         = wr;
    bus.mem_d_addr_i       = addr;
    bus.mem_d_data_wr_i    = wdata;
    bus.mem_d_req_tag_i    = tag;
    bus.mem_d_flush_i      = maint[2];
    bus.mem_d_invalidate_i = maint[1];
    bus.mem_d_writeback_i  = maint[0];
    bus.mem_d_cacheable_i  = 1'b1;
    e.due = cyc + LAT; e.tag = tag; e.err = eerr; e.data = edata; e.chk_data = chk;
    exp_q.push_back(e);
    tick();
    clear_in();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    bus.mem_d_rd_i   = 1'b1;
    bus.mem_d_addr_i = 32'h8000_0000;
    repeat (2) @(posedge clk_i);
    #1;
    cmp("rst_accept", 32'(bus.mem_d_accept_o), 32'd0);
    cmp("rst_ack", 32'(bus.mem_d_ack_o), 32'd0);
    cmp("rst_err", 32'(bus.mem_d_error_o), 32'd0);
    cmp("rst_tag", 32'(bus.mem_d_resp_tag_o), 32'd0);
    cmp("rst_data", bus.mem_d_data_rd_o, 32'd0);
    clear_in();
    rst_i = 1'b1;
    #1;
    cmp("release_accept", 32'(bus.mem_d_accept_o), 32'd1);

    step_name = "wr_then_rd";
    issue(1'b0, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 11'd5, 3'b000, 1'b0, 32'd0, 1'b0);
    issue(1'b1, 4'h0, 32'h8000_0010, 32'd0,         11'd6, 3'b000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    idle(3);

    step_name = "byte_lanes";
    issue(1'b0, 4'hF, 32'h8000_0020, 32'h1122_3344, 11'd1, 3'b000, 1'b0, 32'd0, 1'b0);
    issue(1'b0, 4'h1, 32'h8000_0022, 32'h0000_00AA, 11'd2, 3'b000, 1'b0, 32'd0, 1'b0);
    issue(1'b1, 4'h0, 32'h8000_0020, 32'd0,         11'd3, 3'b000, 1'b0, 32'h1122_33AA, 1'b1);
    issue(1'b1, 4'h2, 32'h8000_0020, 32'h0000_BB00, 11'd4, 3'b000, 1'b0, 32'h1122_33AA, 1'b1);
    issue(1'b1, 4'h0, 32'h8000_0020, 32'd0,         11'd5, 3'b000, 1'b0, 32'h1122_BBAA, 1'b1);
    idle(3);

    step_name = "window_edges";
    issue(1'b0, 4'hF, 32'h8000_0000, 32'hCAFE_F00D, 11'h10, 3'b000, 1'b0, 32'd0, 1'b0);
    issue(1'b0, 4'hF, 32'h8000_0FFC, 32'h0BAD_C0DE, 11'h11, 3'b000, 1'b0, 32'd0, 1'b0);
    issue(1'b0, 4'hF, 32'h8000_1000, 32'h5555_5555, 11'h12, 3'b000, 1'b1, 32'd0, 1'b1);
    issue(1'b0, 4'hF, 32'h7FFF_FFFC, 32'h6666_6666, 11'h13, 3'b000, 1'b1, 32'd0, 1'b1);
    issue(1'b1, 4'h0, 32'h7FFF_FFFC, 32'd0,         11'h14, 3'b000, 1'b1, 32'd0, 1'b1);
    issue(1'b1, 4'h0, 32'h8000_1000, 32'd0,         11'h15, 3'b000, 1'b1, 32'd0, 1'b1);
    issue(1'b1, 4'h0, 32'h8000_0000, 32'd0,         11'h16, 3'b000, 1'b0, 32'hCAFE_F00D, 1'b1);
    issue(1'b1, 4'h0, 32'h8000_0FFC, 32'd0,         11'h17, 3'b000, 1'b0, 32'h0BAD_C0DE, 1'b1);
    issue(1'b1, 4'h0, 32'hFFFF_FFFC, 32'd0,         11'h18, 3'b000, 1'b1, 32'd0, 1'b1);
    idle(3);

    step_name = "back_to_back";
    for (int t = 1; t <= 8; t++) begin
      issue(1'b1, 4'h0, 32'h8000_0010, 32'd0, 11'(t), 3'b000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    end
    idle(3);

    step_name = "maintenance";
    issue(1'b0, 4'h0, 32'h0000_0000, 32'd0,         11'h7FF, 3'b100, 1'b0, 32'd0, 1'b1);
    issue(1'b0, 4'h0, 32'h8000_0020, 32'h9999_9999, 11'h21,  3'b010, 1'b0, 32'd0, 1'b1);
    issue(1'b0, 4'h0, 32'hFFFF_FFF0, 32'd0,         11'h22,  3'b001, 1'b0, 32'd0, 1'b1);
    issue(1'b1, 4'h0, 32'h8000_0020, 32'd0,         11'h23,  3'b000, 1'b0, 32'h1122_BBAA, 1'b1);
    idle(3);

    step_name = "reset_in_flight";
    bus.mem_d_rd_i      = 1'b1;
    bus.mem_d_addr_i    = 32'h8000_0010;
    bus.mem_d_req_tag_i = 11'h31;
    @(posedge clk_i);
    #1;
    bus.mem_d_addr_i    = 32'h8000_0020;
    bus.mem_d_req_tag_i = 11'h32;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clear_in();
    #1;
    cmp("mid_rst_ack", 32'(bus.mem_d_ack_o), 32'd0);
    cmp("mid_rst_accept", 32'(bus.mem_d_accept_o), 32'd0);
    cmp("mid_rst_tag", 32'(bus.mem_d_resp_tag_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    idle(4);
    issue(1'b1, 4'h0, 32'h8000_0010, 32'd0, 11'h33, 3'b000, 1'b0, 32'hDEAD_BEEF, 1'b1);
    issue(1'b1, 4'h0, 32'h8000_0020, 32'd0, 11'h34, 3'b000, 1'b0, 32'h1122_BBAA, 1'b1);
    idle(3);

    step_name = "end";
    cmp("pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h80000000: byte address of word 0 of the window.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words, power of two.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..4: cycles from accept to ack.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port mem_d_addr_i, input, 32: request byte address.
REQ-007 SHALL have port mem_d_data_wr_i, input, 32: write data.
REQ-008 SHALL have port mem_d_rd_i, input, 1: read request.
REQ-009 SHALL have port mem_d_wr_i, input, 4: byte-lane write strobes.
REQ-010 SHALL have port mem_d_cacheable_i, input, 1: cacheable hint, ignored.
REQ-011 SHALL have port mem_d_req_tag_i, input, 11: request tag.
REQ-012 SHALL have port mem_d_invalidate_i, input, 1: invalidate maintenance op.
REQ-013 SHALL have port mem_d_writeback_i, input, 1: writeback maintenance op.
REQ-014 SHALL have port mem_d_flush_i, input, 1: flush maintenance op.
REQ-015 SHALL have port mem_d_data_rd_o, output, 32: read data, valid with ack.
REQ-016 SHALL have port mem_d_accept_o, output, 1: request taken this cycle.
REQ-017 SHALL have port mem_d_ack_o, output, 1: one-cycle response strobe.
REQ-018 SHALL have port mem_d_error_o, output, 1: response error, valid with ack.
REQ-019 SHALL have port mem_d_resp_tag_o, output, 11: tag echoed with ack.

Function
REQ-020 SHALL treat a cycle as a request when any of rd, |wr, flush, invalidate, writeback is high; it is taken when mem_d_accept_o is also high.
REQ-021 SHALL drive mem_d_accept_o high every cycle when DMEM_RESP_STALL_EN is undefined.
REQ-022 SHALL, for a request taken in cycle N, pulse mem_d_ack_o in cycle N+LATENCY exactly once, in request order, with mem_d_resp_tag_o equal to the request tag.
REQ-023 SHALL sustain one taken request per cycle with no response backpressure; up to LATENCY responses in flight, held in a LATENCY-deep shift pipeline of {valid, tag, error, data}.
REQ-024 SHALL index the word by (addr-ADDR_BASE)>>2; addr[1:0] ignored.
REQ-025 SHALL flag in-window when ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS, computed with 33-bit unsigned arithmetic (no wrap at 2^32).
REQ-026 SHALL, for in-window write, update only lanes with wr[k]=1 at the accepting clock edge.
REQ-027 SHALL, for in-window read, capture word contents at the accepting edge; rd with wr!=0 returns pre-write contents.
REQ-028 SHALL make a read taken in the cycle after a write to the same word return the written data.
REQ-029 SHALL, for out-of-window rd or write, ack with error=1, data_rd=0, no memory change.
REQ-030 SHALL ack maintenance-only requests (no rd, wr=0) with error=0, data_rd=0, no memory effect, regardless of address.
REQ-031 SHALL drive mem_d_data_rd_o, mem_d_error_o, mem_d_resp_tag_o to 0 in cycles without ack.

Reset
REQ-032 SHALL, while rst_i is low, force mem_d_ack_o=0, mem_d_error_o=0, mem_d_data_rd_o=0, mem_d_resp_tag_o=0, mem_d_accept_o=0, clear all pipeline valid bits.
REQ-033 SHALL drop in-flight responses on reset mid-operation; none emitted after release.
REQ-034 SHALL NOT clear memory contents on reset.
REQ-035 SHALL raise mem_d_accept_o in the first cycle after rst_i deasserts.

Configuration
REQ-036 SHALL, with DMEM_RESP_STALL_EN defined, run a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset, advances every cycle) and drive mem_d_accept_o low whenever LFSR[1:0]==2'b11.
REQ-037 SHALL, with DMEM_RESP_STALL_EN defined, take no action on an unaccepted request; the initiator holds it.
REQ-038 SHALL, with DMEM_RESP_STALL_EN undefined, contain no LFSR; accept per REQ-021.

Verification
REQ-039 SHALL cover: write 0xDEADBEEF wr=4'hF to 0x80000010 tag 5, then read tag 6 next cycle -> acks at N+2 and N+3 with tags 5, 6; second data 0xDEADBEEF, error 0.
REQ-040 SHALL cover: word 0x11223344, write 0x000000AA wr=4'h1, read -> 0x112233AA.
REQ-041 SHALL cover: read 0x7FFFFFFC and 0x80001000 (DEPTH_WORDS=1024) -> both ack error=1, data 0; window contents unchanged.
REQ-042 SHALL cover: back-to-back reads tags 1..8 every cycle -> eight consecutive acks, tags 1..8 in order, LATENCY cycles after each.
REQ-043 SHALL cover: flush at 0x00000000 tag 0x7FF -> ack error=0, data 0, tag 0x7FF.
REQ-044 SHALL cover: two reads in flight, rst_i low one cycle -> no ack after release; next read returns pre-reset memory contents.
